// File: rtl/ir_cmd_decoder.sv
// NEC frame validator and key decoder for the music control unit.
// Pulse/error outputs land 3 cycles after the ready rising edge; edges arriving while busy are dropped.
module ir_cmd_decoder #(
  parameter int unsigned HOLDOFF_CYCLES = 12_500_000,
  parameter bit          CHECK_CUSTOM   = 1'b1,
  parameter logic [15:0] CUSTOM_CODE    = 16'h6B86
) (
  input  logic        CLOCK,
  input  logic        iRST_n,
  input  logic        iDATA_READY,
  input  logic [31:0] iDATA,
  output logic        oRESET_CMD,
  output logic        oPLAYPAUSE,
  output logic        oRESTART,
  output logic        oNEXT,
  output logic        oPREV,
  output logic        oFAST,
  output logic        oSLOW,
  output logic [7:0]  oKEY,
  output logic        oERR,
  output logic [7:0]  oERR_CNT
);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK} state_t;

  localparam logic [23:0] HOLDOFF_LD = 24'(HOLDOFF_CYCLES);

  state_t      state, state_nxt;
  logic        rdy_q;
  logic [31:0] frame;
  logic [23:0] holdoff;
  logic [7:0]  last_key;
  logic        last_vld;
  logic [7:0]  key;
  logic        frame_bad;
  logic        do_err, do_rep, do_acc;

  assign key       = frame[23:16];
  assign frame_bad = (frame[31:24] != ~frame[23:16]) ||
                     (CHECK_CUSTOM && (frame[15:0] != CUSTOM_CODE));

  always_ff @(posedge CLOCK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_err    = 1'b0;
    do_rep    = 1'b0;
    do_acc    = 1'b0;
    case (state)
      IDLE:    if (iDATA_READY && !rdy_q) state_nxt = CAPTURE;
      CAPTURE: state_nxt = CHECK;
      CHECK: begin
        state_nxt = IDLE;
        if (frame_bad)                                        do_err = 1'b1;
        else if (last_vld && key == last_key && holdoff != '0) do_rep = 1'b1;
        else                                                  do_acc = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge iRST_n) begin
    if (!iRST_n) begin
      rdy_q      <= 1'b0;
      frame      <= '0;
      holdoff    <= '0;
      last_key   <= '0;
      last_vld   <= 1'b0;
      oRESET_CMD <= 1'b0;
      oPLAYPAUSE <= 1'b0;
      oRESTART   <= 1'b0;
      oNEXT      <= 1'b0;
      oPREV      <= 1'b0;
      oFAST      <= 1'b0;
      oSLOW      <= 1'b0;
      oKEY       <= '0;
      oERR       <= 1'b0;
      oERR_CNT   <= '0;
    end else begin
      rdy_q <= iDATA_READY;
      if (state == CAPTURE) frame <= iDATA;

      // A held key keeps refreshing the window, so it never times out while repeating.
      if (do_rep || do_acc)    holdoff <= HOLDOFF_LD;
      else if (holdoff != '0)  holdoff <= holdoff - 24'd1;

      oRESET_CMD <= do_acc && (key == 8'h12);
      oPLAYPAUSE <= do_acc && (key == 8'h16);
      oRESTART   <= do_acc && (key == 8'h17);
      oNEXT      <= do_acc && (key == 8'h18);
      oPREV      <= do_acc && (key == 8'h14);
      oERR       <= do_err;

      if (do_err && oERR_CNT != 8'hFF) oERR_CNT <= oERR_CNT + 8'd1;

      if (do_acc) begin
        last_key <= key;
        last_vld <= 1'b1;
        oKEY     <= key;
        case (key)
          8'h10:   begin oFAST <= 1'b1; oSLOW <= 1'b0; end
          8'h0F:   begin oFAST <= 1'b0; oSLOW <= 1'b1; end
          8'h13:   begin oFAST <= 1'b0; oSLOW <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Directed table, reset corner cases and randomized frames against a frame-level reference model.
module tb_ir_cmd_decoder;

  localparam int H = 100;

  logic        CLOCK = 1'b0;
  logic        iRST_n;
  logic        iDATA_READY;
  logic [31:0] iDATA;
  logic        oRESET_CMD, oPLAYPAUSE, oRESTART, oNEXT, oPREV, oFAST, oSLOW, oERR;
  logic [7:0]  oKEY, oERR_CNT;
  logic        nc_reset, nc_pp, nc_restart, nc_next, nc_prev, nc_fast, nc_slow, nc_err;
  logic [7:0]  nc_key, nc_cnt;

  ir_cmd_decoder #(.HOLDOFF_CYCLES(H), .CHECK_CUSTOM(1'b1), .CUSTOM_CODE(16'h6B86)) dut (
    .CLOCK(CLOCK), .iRST_n(iRST_n), .iDATA_READY(iDATA_READY), .iDATA(iDATA),
    .oRESET_CMD(oRESET_CMD), .oPLAYPAUSE(oPLAYPAUSE), .oRESTART(oRESTART), .oNEXT(oNEXT),
    .oPREV(oPREV), .oFAST(oFAST), .oSLOW(oSLOW), .oKEY(oKEY), .oERR(oERR), .oERR_CNT(oERR_CNT));

  ir_cmd_decoder #(.HOLDOFF_CYCLES(H), .CHECK_CUSTOM(1'b0), .CUSTOM_CODE(16'h6B86)) dut_nc (
    .CLOCK(CLOCK), .iRST_n(iRST_n), .iDATA_READY(iDATA_READY), .iDATA(iDATA),
    .oRESET_CMD(nc_reset), .oPLAYPAUSE(nc_pp), .oRESTART(nc_restart), .oNEXT(nc_next),
    .oPREV(nc_prev), .oFAST(nc_fast), .oSLOW(nc_slow), .oKEY(nc_key), .oERR(nc_err), .oERR_CNT(nc_cnt));

  always #10 CLOCK = ~CLOCK;

  typedef struct {
    logic [4:0] pulse;  // {reset, playpause, restart, next, prev}
    logic       err;
    logic [7:0] key;
    logic       fast;
    logic       slow;
    logic [7:0] cnt;
  } res_t;

  typedef struct {
    logic [31:0] data;
    int          gap;
    res_t        e;
  } vec_t;

  vec_t        vecs[$];
  int          n_chk = 0;
  int          n_fail = 0;
  longint      edge_n = 0;
  logic        s_nc_pp;
  logic [7:0]  s_nc_key;
  logic [4:0]  pulses;

  assign pulses = {oRESET_CMD, oPLAYPAUSE, oRESTART, oNEXT, oPREV};

  // Reference model state: whole-frame view with holdoff tracked as the edge of the last reload.
  logic [7:0] m_last, m_key, m_cnt;
  logic       m_vld, m_fast, m_slow;
  longint     m_reload;

  task automatic model_reset();
    m_last = 0; m_key = 0; m_cnt = 0; m_vld = 0; m_fast = 0; m_slow = 0;
    m_reload = -1_000_000;
  endtask

  task automatic model(input logic [31:0] d, input longint ce, output res_t e);
    logic [7:0] k;
    k = d[23:16];
    e.pulse = 5'b0; e.err = 1'b0;
    if (d[31:24] != ~k || d[15:0] != 16'h6B86) begin
      e.err = 1'b1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (m_vld && k == m_last && (ce - m_reload) <= H) begin
      m_reload = ce;
    end else begin
      m_reload = ce; m_last = k; m_vld = 1; m_key = k;
      case (k)
        8'h12: e.pulse = 5'b10000;
        8'h16: e.pulse = 5'b01000;
        8'h17: e.pulse = 5'b00100;
        8'h18: e.pulse = 5'b00010;
        8'h14: e.pulse = 5'b00001;
        8'h10: begin m_fast = 1; m_slow = 0; end
        8'h0F: begin m_fast = 0; m_slow = 1; end
        8'h13: begin m_fast = 0; m_slow = 0; end
        default: ;
      endcase
    end
    e.key = m_key; e.fast = m_fast; e.slow = m_slow; e.cnt = m_cnt;
  endtask

  function automatic logic [31:0] mk(input logic [7:0] k);
    return {~k, k, 16'h6B86};
  endfunction

  task automatic add(input logic [31:0] d, input int gap, input logic [4:0] p, input logic er,
                     input logic [7:0] k, input logic f, input logic s, input logic [7:0] c);
    vec_t v;
    v.data = d; v.gap = gap;
    v.e.pulse = p; v.e.err = er; v.e.key = k; v.e.fast = f; v.e.slow = s; v.e.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    edge_n++;
  endtask

  // Drives one frame at a negedge; P0 samples ready, P2 is the CHECK edge, outputs seen in cycle 3.
  task automatic run_frame(input logic [31:0] d, input bit rel, input res_t e);
    @(negedge CLOCK);
    iDATA = d; iDATA_READY = 1'b1;
    if (rel) iRST_n = 1'b1;
    tick(); tick();
    #1 chk("early_pulse", {27'b0, pulses, oERR}, 32'h0);
    tick();
    #1;
    chk("pulse", {27'b0, pulses}, {27'b0, e.pulse});
    chk("err", {31'b0, oERR}, {31'b0, e.err});
    chk("key", {24'b0, oKEY}, {24'b0, e.key});
    chk("speed", {30'b0, oFAST, oSLOW}, {30'b0, e.fast, e.slow});
    chk("err_cnt", {24'b0, oERR_CNT}, {24'b0, e.cnt});
    s_nc_pp = nc_pp; s_nc_key = nc_key;
    iDATA_READY = 1'b0;
    tick();
    #1 chk("late_pulse", {27'b0, pulses, oERR}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge CLOCK);
    iRST_n = 1'b0; iDATA_READY = 1'b0;
    repeat (2) @(negedge CLOCK);
    iRST_n = 1'b1;
    model_reset();
  endtask

  res_t e;
  res_t z;

  initial begin
    iRST_n = 1'b0; iDATA_READY = 1'b0; iDATA = '0;
    model_reset();
    z = '{pulse: 5'b0, err: 1'b0, key: 8'h0, fast: 1'b0, slow: 1'b0, cnt: 8'h0};

    //             data              gap  pulse    err key    f  s  cnt
    add(mk(8'h16),         2,   5'b01000, 0, 8'h16, 0, 0, 0);
    add(mk(8'h16),         46,  5'b00000, 0, 8'h16, 0, 0, 0);
    add(mk(8'h16),         66,  5'b00000, 0, 8'h16, 0, 0, 0);
    add(mk(8'h16),         176, 5'b01000, 0, 8'h16, 0, 0, 0);
    add(mk(8'h16),         96,  5'b00000, 0, 8'h16, 0, 0, 0);
    add(mk(8'h16),         97,  5'b01000, 0, 8'h16, 0, 0, 0);
    add(mk(8'h18),         0,   5'b00010, 0, 8'h18, 0, 0, 0);
    add(32'h0016_6B86,     0,   5'b00000, 1, 8'h18, 0, 0, 1);
    add(mk(8'h18),         0,   5'b00000, 0, 8'h18, 0, 0, 1);
    add(mk(8'h10),         120, 5'b00000, 0, 8'h10, 1, 0, 1);
    add(mk(8'h0F),         120, 5'b00000, 0, 8'h0F, 0, 1, 1);
    add(mk(8'h13),         120, 5'b00000, 0, 8'h13, 0, 0, 1);
    add(mk(8'h12),         0,   5'b10000, 0, 8'h12, 0, 0, 1);
    add(mk(8'h17),         0,   5'b00100, 0, 8'h17, 0, 0, 1);
    add(mk(8'h14),         0,   5'b00001, 0, 8'h14, 0, 0, 1);
    add(mk(8'h55),         0,   5'b00000, 0, 8'h55, 0, 0, 1);
    add(mk(8'h55),         0,   5'b00000, 0, 8'h55, 0, 0, 1);

    repeat (3) @(negedge CLOCK);
    #1;
    chk("rst_pulse", {27'b0, pulses, oERR}, 32'h0);
    chk("rst_key_cnt", {16'b0, oKEY, oERR_CNT}, 32'h0);
    chk("rst_speed", {30'b0, oFAST, oSLOW}, 32'h0);
    @(negedge CLOCK);
    iRST_n = 1'b1;

    foreach (vecs[i]) begin
      repeat (vecs[i].gap) tick();
      run_frame(vecs[i].data, 1'b0, vecs[i].e);
    end

    // Bad-inverse frames until the error counter saturates.
    for (int i = 0; i < 299; i++) begin
      e = '{pulse: 5'b0, err: 1'b1, key: 8'h55, fast: 1'b0, slow: 1'b0,
            cnt: (i + 2 > 255) ? 8'd255 : 8'(i + 2)};
      run_frame(32'h0016_6B86, 1'b0, e);
    end

    // Reset in cycle 1 of a next-key frame aborts it.
    @(negedge CLOCK);
    iDATA = mk(8'h18); iDATA_READY = 1'b1;
    tick();
    #2 iRST_n = 1'b0;
    #1;
    chk("abort_outputs", {9'b0, pulses, oERR, oFAST, oSLOW, oKEY, oERR_CNT}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1 chk("abort_next", {31'b0, oNEXT}, 32'h0);
    end
    @(negedge CLOCK) iDATA_READY = 1'b0;
    @(negedge CLOCK) iRST_n = 1'b1;
    repeat (3) tick();
    e = z; e.pulse = 5'b00010; e.key = 8'h18;
    run_frame(mk(8'h18), 1'b0, e);

    // Ready already high when reset releases counts as a rising edge.
    repeat (2) tick();
    @(negedge CLOCK);
    iRST_n = 1'b0; iDATA = mk(8'h17); iDATA_READY = 1'b1;
    e = z; e.pulse = 5'b00100; e.key = 8'h17;
    run_frame(mk(8'h17), 1'b1, e);

    // Foreign custom code: rejected with checking on, accepted with it off.
    repeat (2) tick();
    e = z; e.err = 1'b1; e.key = 8'h17; e.cnt = 8'd1;
    run_frame(32'hE916_1234, 1'b0, e);
    chk("nocheck_playpause", {31'b0, s_nc_pp}, 32'h1);
    chk("nocheck_key", {24'b0, s_nc_key}, 32'h16);

    // Randomized frames against the reference model.
    do_reset();
    begin
      logic [7:0] keys [9];
      logic [7:0] k, prev_k;
      logic [31:0] d;
      int gap;
      keys = '{8'h12, 8'h16, 8'h17, 8'h18, 8'h14, 8'h10, 8'h0F, 8'h13, 8'h00};
      prev_k = 8'h16;
      for (int i = 0; i < 200; i++) begin
        gap = $urandom_range(0, 140);
        if ($urandom_range(0, 9) < 4) k = prev_k;
        else begin
          k = keys[$urandom_range(0, 8)];
          if (k == 8'h00) k = 8'($urandom);
        end
        prev_k = k;
        d = mk(k);
        case ($urandom_range(0, 7))
          0: d[31:24] = d[31:24] ^ (8'h1 << $urandom_range(0, 7));
          1: d[15:0]  = d[15:0] ^ (16'h1 << $urandom_range(0, 15));
          default: ;
        endcase
        repeat (gap) tick();
        model(d, edge_n + 3, e);
        run_frame(d, 1'b0, e);
        chk("fast_slow_exclusive", {31'b0, oFAST & oSLOW}, 32'h0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
